// File: rtl/cic_pkg.sv
// Shared width derivation and rounding-mode constants for the CIC decimator.
package cic_pkg;

    localparam int unsigned ROUND_TRUNC   = 0;
    localparam int unsigned ROUND_HALF_UP = 1;

    // Smallest b such that 2**b >= value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

    // Accumulator width that holds the worst-case growth R_MAX**ORDER.
    function automatic int unsigned acc_width(input int unsigned data_w,
                                              input int unsigned order,
                                              input int unsigned r_max);
        return data_w + order * clog2(r_max);
    endfunction

    // Right shift applied to the comb result; zero or negative means sign-extend.
    function automatic int out_shift(input int unsigned acc_w, input int unsigned out_w);
        return int'(acc_w) - int'(out_w);
    endfunction

endpackage

// File: rtl/cic_integrator_stage.sv
// One CIC integrator: a modular accumulator that adds add_i on each enabled cycle.
module cic_integrator_stage
    import cic_pkg::*;
#(
    parameter int unsigned W = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic [W-1:0] add_i,
    output logic [W-1:0] acc_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;

    // Wrap-around is intended; the combs cancel it.
    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = acc_q + add_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cic_decimator.sv
// Single-clock CIC decimator: ORDER integrators, run-time decimate-by-R, ORDER combs,
// then truncating or rounding/saturating output scaling.
module cic_decimator
    import cic_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 9,
    parameter  int unsigned OUT_WIDTH  = 9,
    parameter  int unsigned ORDER      = 3,
    parameter  int unsigned R_MAX      = 4,
    parameter  int unsigned ROUND      = 0,
    localparam int unsigned ACC_W      = acc_width(DATA_WIDTH, ORDER, R_MAX),
    localparam int unsigned RATE_W     = clog2(R_MAX + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         ena_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic [RATE_W-1:0]            rate_i,
    output logic signed [OUT_WIDTH-1:0]  data_o,
    output logic                         valid_o
);

    localparam int SHIFT = out_shift(ACC_W, OUT_WIDTH);

    logic [ACC_W-1:0]     int_w [ORDER+1];
    logic [RATE_W-1:0]    rate_san_w;
    logic [RATE_W-1:0]    cnt_q, cnt_d;
    logic [RATE_W-1:0]    rate_q, rate_d;
    logic                 strobe_q, strobe_d;
    logic [ACC_W-1:0]     dly_q [ORDER];
    logic [ACC_W-1:0]     dly_d [ORDER];
    logic [ACC_W-1:0]     comb_w;
    logic [OUT_WIDTH-1:0] scaled_w;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    // Integrator pipeline: stage k accumulates the registered output of stage k-1.
    assign int_w[0] = ACC_W'(data_i);

    for (genvar k = 1; k <= ORDER; k++) begin : g_int
        cic_integrator_stage #(
            .W (ACC_W)
        ) u_int (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (ena_i),
            .add_i (int_w[k-1]),
            .acc_o (int_w[k])
        );
    end

    // Unsupported ratios fall back to the maximum.
    always_comb begin
        rate_san_w = rate_i;
        if (rate_i < RATE_W'(2) || rate_i > RATE_W'(R_MAX)) begin
            rate_san_w = RATE_W'(R_MAX);
        end
    end

    // Frame counter; the ratio is re-latched only at the frame boundary.
    always_comb begin
        cnt_d    = cnt_q;
        rate_d   = rate_q;
        strobe_d = 1'b0;
        if (ena_i) begin
            if (cnt_q == rate_q - RATE_W'(1)) begin
                cnt_d    = '0;
                strobe_d = 1'b1;
                rate_d   = rate_san_w;
            end else begin
                cnt_d = cnt_q + RATE_W'(1);
            end
        end
    end

    always_comb begin : comb_chain
        logic [ACC_W-1:0] acc;
        acc = int_w[ORDER];
        for (int k = 0; k < ORDER; k++) begin
            dly_d[k] = acc;
            acc      = acc - dly_q[k];
        end
        comb_w = acc;
    end

    if (SHIFT <= 0) begin : g_ext
        assign scaled_w = OUT_WIDTH'($signed(comb_w));
    end else if (ROUND == ROUND_HALF_UP) begin : g_round
        localparam int unsigned   TOP_W = ACC_W - OUT_WIDTH + 2;
        localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);

        logic [ACC_W:0]        rnd_w;
        logic signed [ACC_W:0] sh_w;
        logic [TOP_W-1:0]      top_w;

        // One guard bit keeps the +half from overflowing before the shift.
        assign rnd_w = {comb_w[ACC_W-1], comb_w} + HALF;
        assign sh_w  = $signed(rnd_w) >>> SHIFT;
        assign top_w = sh_w[ACC_W:OUT_WIDTH-1];

        always_comb begin
            scaled_w = sh_w[OUT_WIDTH-1:0];
            if (top_w != '0 && top_w != '1) begin
                scaled_w = sh_w[ACC_W] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                       : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end
        end
    end else begin : g_trunc
        assign scaled_w = OUT_WIDTH'($signed(comb_w) >>> SHIFT);
    end

    always_comb begin
        data_d  = data_q;
        valid_d = strobe_q;
        if (strobe_q) begin
            data_d = scaled_w;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            rate_q   <= rate_san_w;
            strobe_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) begin
                dly_q[k] <= '0;
            end
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rate_q   <= rate_d;
            strobe_q <= strobe_d;
            if (strobe_q) begin
                for (int k = 0; k < ORDER; k++) begin
                    dly_q[k] <= dly_d[k];
                end
            end
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Bench for cic_decimator: truncating and rounding instances against a closed-form CIC model.
module tb_cic_decimator;

    localparam int unsigned DW   = 9;
    localparam int unsigned OW   = 9;
    localparam int unsigned N    = 3;
    localparam int unsigned RMAX = 4;
    localparam int unsigned ACCW = 15;
    localparam int unsigned RW   = 3;
    localparam int          SHIFT = int'(ACCW) - int'(OW);

    logic                 clk  = 1'b0;
    logic                 rst  = 1'b1;
    logic                 ena  = 1'b0;
    logic signed [DW-1:0] din  = '0;
    logic [RW-1:0]        rate = RW'(4);
    logic signed [OW-1:0] dout_t, dout_r;
    logic                 vld_t, vld_r;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: accepted samples since reset, and int_N sampled at each frame end.
    longint xs[$];
    longint vs[$];
    int     cnt_m  = 0;
    int     rate_m = 4;
    bit     pend_m = 1'b0;
    longint pend_t = 0, pend_r = 0;
    bit     exp_v  = 1'b0;
    longint exp_t  = 0, exp_r = 0;

    int     seq_q[$];
    longint outs_cur[$];

    always #5 clk = ~clk;

    cic_decimator #(
        .DATA_WIDTH (DW), .OUT_WIDTH (OW), .ORDER (N), .R_MAX (RMAX), .ROUND (0)
    ) u_dut_trunc (
        .clk_i (clk), .rst_i (rst), .ena_i (ena), .data_i (din), .rate_i (rate),
        .data_o (dout_t), .valid_o (vld_t)
    );

    cic_decimator #(
        .DATA_WIDTH (DW), .OUT_WIDTH (OW), .ORDER (N), .R_MAX (RMAX), .ROUND (1)
    ) u_dut_round (
        .clk_i (clk), .rst_i (rst), .ena_i (ena), .data_i (din), .rate_i (rate),
        .data_o (dout_r), .valid_o (vld_r)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int san(input int r);
        return (r < 2 || r > int'(RMAX)) ? int'(RMAX) : r;
    endfunction

    function automatic longint binom(input longint n, input int k);
        longint res = 1;
        if (n < k) return 0;
        for (int i = 0; i < k; i++) res = res * (n - i) / (i + 1);
        return res;
    endfunction

    function automatic longint wrap_acc(input longint v);
        longint m = v & ((longint'(1) << ACCW) - 1);
        return (m >= (longint'(1) << (ACCW - 1))) ? m - (longint'(1) << ACCW) : m;
    endfunction

    // N-fold running sum after j accepts: sum_i x_i * C(j-i, N-1), i 1-based.
    function automatic longint integ_n();
        longint s = 0;
        longint j = longint'(xs.size());
        for (int i = 0; i < xs.size(); i++) s += xs[i] * binom(j - 1 - i, N - 1);
        return wrap_acc(s);
    endfunction

    // N-th backward difference of the decimated integral, zero history before reset.
    function automatic longint comb_n();
        longint s = 0;
        int     k = vs.size();
        for (int m = 0; m <= int'(N); m++) begin
            if (k - 1 - m >= 0) s += ((m % 2 == 1) ? -1 : 1) * binom(N, m) * vs[k - 1 - m];
        end
        return wrap_acc(s);
    endfunction

    function automatic longint scale_trunc(input longint y);
        return y >>> SHIFT;
    endfunction

    function automatic longint scale_round(input longint y);
        longint r = (y + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        if (r > 255) r = 255;
        if (r < -256) r = -256;
        return r;
    endfunction

    task automatic model_edge(input bit r, input bit e, input int d, input int rt);
        longint y;
        if (r) begin
            xs.delete();
            vs.delete();
            cnt_m  = 0;
            rate_m = san(rt);
            pend_m = 1'b0;
            exp_v  = 1'b0;
            exp_t  = 0;
            exp_r  = 0;
        end else begin
            exp_v = pend_m;
            if (pend_m) begin
                exp_t = pend_t;
                exp_r = pend_r;
            end
            pend_m = 1'b0;
            if (e) begin
                xs.push_back(longint'(d));
                cnt_m++;
                if (cnt_m == rate_m) begin
                    cnt_m = 0;
                    vs.push_back(integ_n());
                    y      = comb_n();
                    pend_m = 1'b1;
                    pend_t = scale_trunc(y);
                    pend_r = scale_round(y);
                    rate_m = san(rt);
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit e, input int d, input int rt);
        rst  = r;
        ena  = e;
        din  = DW'(d);
        rate = RW'(rt);
        @(posedge clk);
        model_edge(r, e, d, rt);
        #1;
        check_eq("valid_t", vld_t, exp_v);
        check_eq("valid_r", vld_r, exp_v);
        check_eq("data_t", $signed(dout_t), exp_t);
        check_eq("data_r", $signed(dout_r), exp_r);
        @(negedge clk);
    endtask

    task automatic run_to_valid(input int d, input int rt, output int cycles);
        cycles = 0;
        do begin
            step(1'b0, 1'b1, d, rt);
            cycles++;
        end while (!vld_t && cycles < 40);
        if (!vld_t) check_eq("valid_timeout", vld_t, 1);
    endtask

    task automatic feed(input bit gapped);
        outs_cur.delete();
        for (int i = 0; i < seq_q.size(); i++) begin
            step(1'b0, 1'b1, seq_q[i], 4);
            if (vld_t) outs_cur.push_back(longint'(dout_t));
            if (gapped) begin
                step(1'b0, 1'b0, 0, 4);
                if (vld_t) outs_cur.push_back(longint'(dout_t));
            end
        end
        repeat (4) begin
            step(1'b0, 1'b0, 0, 4);
            if (vld_t) outs_cur.push_back(longint'(dout_t));
        end
    endtask

    initial begin
        int cyc;
        int cur_rate;
        @(negedge clk);

        // Reset state; ena_i is ignored while reset is held.
        step(1'b1, 1'b0, 0, 4);
        step(1'b1, 1'b1, 37, 4);
        check_eq("rst_valid", vld_t, 0);
        check_eq("rst_data", $signed(dout_t), 0);

        // DC 100 at R=4 has unity gain.
        repeat (40) step(1'b0, 1'b1, 100, 4);
        run_to_valid(100, 4, cyc);
        check_eq("dc100_t", $signed(dout_t), 100);
        check_eq("dc100_r", $signed(dout_r), 100);
        run_to_valid(100, 4, cyc);
        check_eq("dc100_spacing", cyc, 4);

        // Mid-frame switch to R=2: current frame still completes at 4.
        step(1'b0, 1'b1, 100, 4);
        run_to_valid(100, 2, cyc);
        check_eq("ratechg_first", cyc, 3);
        run_to_valid(100, 2, cyc);
        check_eq("ratechg_spacing", cyc, 2);
        repeat (20) step(1'b0, 1'b1, 100, 2);
        run_to_valid(100, 2, cyc);
        check_eq("r2_dc_t", $signed(dout_t), 12);
        check_eq("r2_dc_r", $signed(dout_r), 13);

        // Negative full scale.
        step(1'b1, 1'b0, 0, 4);
        repeat (40) step(1'b0, 1'b1, -256, 4);
        run_to_valid(-256, 4, cyc);
        check_eq("neg_fs_t", $signed(dout_t), -256);
        check_eq("neg_fs_r", $signed(dout_r), -256);

        // Positive full scale long enough for the integrators to wrap many times.
        step(1'b1, 1'b0, 0, 4);
        repeat (4000) step(1'b0, 1'b1, 255, 4);
        run_to_valid(255, 4, cyc);
        check_eq("wrap_t", $signed(dout_t), 255);
        check_eq("wrap_r", $signed(dout_r), 255);

        // Impulse of 64: frame sums 192, 768, 64, 0 before the >>6.
        step(1'b1, 1'b0, 0, 4);
        step(1'b0, 1'b1, 64, 4);
        run_to_valid(0, 4, cyc);
        check_eq("imp_f1", $signed(dout_t), 3);
        check_eq("imp_f1_lat", cyc, 4);
        run_to_valid(0, 4, cyc);
        check_eq("imp_f2", $signed(dout_t), 12);
        run_to_valid(0, 4, cyc);
        check_eq("imp_f3", $signed(dout_t), 1);
        run_to_valid(0, 4, cyc);
        check_eq("imp_f4", $signed(dout_t), 0);

        // Out-of-range ratios behave as R_MAX.
        step(1'b1, 1'b0, 0, 0);
        repeat (30) step(1'b0, 1'b1, 100, 0);
        run_to_valid(100, 0, cyc);
        run_to_valid(100, 0, cyc);
        check_eq("rate0_spacing", cyc, 4);
        check_eq("rate0_dc", $signed(dout_t), 100);
        repeat (12) step(1'b0, 1'b1, 100, 7);
        run_to_valid(100, 7, cyc);
        run_to_valid(100, 7, cyc);
        check_eq("rate7_spacing", cyc, 4);
        check_eq("rate7_dc", $signed(dout_t), 100);

        // Gapped enable gives one output per four accepted samples.
        seq_q.delete();
        repeat (48) seq_q.push_back(int'($urandom_range(0, 511)) - 256);
        step(1'b1, 1'b0, 0, 4);
        feed(1'b0);
        check_eq("ungapped_count", outs_cur.size(), 12);
        step(1'b1, 1'b0, 0, 4);
        feed(1'b1);
        check_eq("gapped_count", outs_cur.size(), 12);

        // Reset on the cycle a strobe is pending: nothing is emitted afterwards.
        step(1'b1, 1'b0, 0, 4);
        repeat (10) step(1'b0, 1'b1, 50, 4);
        run_to_valid(50, 4, cyc);
        repeat (3) step(1'b0, 1'b1, 50, 4);
        step(1'b1, 1'b1, 50, 4);
        check_eq("midrst_valid", vld_t, 0);
        check_eq("midrst_data", $signed(dout_t), 0);
        step(1'b0, 1'b0, 50, 4);
        check_eq("midrst_no_pending", vld_t, 0);
        run_to_valid(50, 4, cyc);
        check_eq("midrst_restart", cyc, 5);

        // Random data, enable, ratio changes and occasional resets.
        cur_rate = 4;
        step(1'b1, 1'b0, 0, cur_rate);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) cur_rate = int'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 511)) - 256, cur_rate);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
